// File: rtl/uart_rx_frame_chk_pkg.sv
// rtl/uart_rx_frame_chk_pkg.sv - shared types and parameter limits for the UART RX frame checker
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } frame_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  function automatic logic params_legal(input int data_width, input int stop_bits);
    return (data_width >= DATA_WIDTH_MIN) && (data_width <= DATA_WIDTH_MAX) &&
           (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_frame_chk_if.sv
// rtl/uart_rx_frame_chk_if.sv - sampler-side inputs and frame result outputs of the checker
interface uart_rx_frame_chk_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
);
  logic                  chk_en;
  logic                  frame_start;
  logic                  sample_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_typ;
  logic                  cnt_clr;
  logic                  busy;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [CNT_W-1:0]      glitch_cnt;
  logic [CNT_W-1:0]      par_err_cnt;
  logic [CNT_W-1:0]      stp_err_cnt;

  modport master (
    output chk_en, frame_start, sample_valid, sampled_bit, par_en, par_typ, cnt_clr,
    input  busy, p_data, data_valid, strt_glitch, par_err, stp_err,
    input  glitch_cnt, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  chk_en, frame_start, sample_valid, sampled_bit, par_en, par_typ, cnt_clr,
    output busy, p_data, data_valid, strt_glitch, par_err, stp_err,
    output glitch_cnt, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_chk_sat_counter.sv
// rtl/uart_rx_frame_chk_sat_counter.sv - saturating event counter with priority clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// rtl/uart_rx_frame_chk.sv - UART RX frame checker: start/data/parity/stop validation with error counters
module uart_rx_frame_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_W      = 8
) (
  input logic                CLK,
  input logic                RST,
  uart_rx_frame_chk_if.slave bus
);

  localparam int BC_W = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_WIDTH - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  if (!params_legal(DATA_WIDTH, STOP_BITS)) begin : g_param_err
    $error("uart_rx_frame_chk: DATA_WIDTH or STOP_BITS out of range");
  end

  frame_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_run_q, par_run_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  stp_now;

  // Pulses are decided on the last stop sample so they are visible during DONE.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    par_run_d     = par_run_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_flag_d    = par_flag_q;
    stp_flag_d    = stp_flag_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    stp_now       = 1'b0;

    if (!bus.chk_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            state_d    = ST_START;
            par_en_d   = bus.par_en;
            par_typ_d  = bus.par_typ;
            shift_d    = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_run_d  = 1'b0;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
          end
        end
        ST_START: begin
          if (bus.sample_valid) begin
            if (bus.sampled_bit) begin
              strt_glitch_d = 1'b1;
              state_d       = ST_IDLE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.sample_valid) begin
            shift_d   = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
            par_run_d = par_run_q ^ bus.sampled_bit;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bus.sample_valid) begin
            par_flag_d = bus.sampled_bit ^ par_run_q ^ par_typ_q;
            state_d    = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bus.sample_valid) begin
            stp_now    = stp_flag_q | ~bus.sampled_bit;
            stp_flag_d = stp_now;
            stop_cnt_d = stop_cnt_q + 1'b1;
            if (stop_cnt_q == STOP_LAST) begin
              state_d = ST_DONE;
              if (!par_flag_q && !stp_now) begin
                data_valid_d = 1'b1;
                p_data_d     = shift_q;
              end else begin
                par_err_d = par_flag_q;
                stp_err_d = stp_now;
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      par_run_q     <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_flag_q    <= 1'b0;
      stp_flag_q    <= 1'b0;
      busy_q        <= 1'b0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      par_run_q     <= par_run_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_flag_q    <= par_flag_d;
      stp_flag_q    <= stp_flag_d;
      busy_q        <= busy_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_glitch_cnt (
    .CLK(CLK), .RST(RST), .inc(strt_glitch_q), .clr(bus.cnt_clr), .count(bus.glitch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_par_err_cnt (
    .CLK(CLK), .RST(RST), .inc(par_err_q), .clr(bus.cnt_clr), .count(bus.par_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stp_err_cnt (
    .CLK(CLK), .RST(RST), .inc(stp_err_q), .clr(bus.cnt_clr), .count(bus.stp_err_cnt)
  );

  assign bus.busy        = busy_q;
  assign bus.p_data      = p_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.strt_glitch = strt_glitch_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb/tb_uart_rx_frame_chk.sv - randomized frame checker bench against a frame-level reference model
module tb_uart_rx_frame_chk;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, chk_en, fs, sv, sbit, pe, pt, clr;

  uart_rx_frame_chk_if #(.DATA_WIDTH(DW), .CNT_W(8)) if0 ();
  uart_rx_frame_chk_if #(.DATA_WIDTH(DW), .CNT_W(2)) if1 ();

  assign if0.chk_en = chk_en;  assign if1.chk_en = chk_en;
  assign if0.frame_start = fs;  assign if1.frame_start = fs;
  assign if0.sample_valid = sv; assign if1.sample_valid = sv;
  assign if0.sampled_bit = sbit; assign if1.sampled_bit = sbit;
  assign if0.par_en = pe;  assign if1.par_en = pe;
  assign if0.par_typ = pt; assign if1.par_typ = pt;
  assign if0.cnt_clr = clr; assign if1.cnt_clr = clr;

  uart_rx_frame_chk #(.DATA_WIDTH(DW), .STOP_BITS(1), .CNT_W(8)) dut0 (
    .CLK(clk), .RST(rst), .bus(if0.slave)
  );
  uart_rx_frame_chk #(.DATA_WIDTH(DW), .STOP_BITS(2), .CNT_W(2)) dut1 (
    .CLK(clk), .RST(rst), .bus(if1.slave)
  );

  // Flattened view of both instances so checks can loop over them.
  logic dv_w[2], gl_w[2], pe_w[2], se_w[2], busy_w[2];
  int   pd_w[2], gc_w[2], pc_w[2], sc_w[2];
  assign dv_w[0] = if0.data_valid;  assign dv_w[1] = if1.data_valid;
  assign gl_w[0] = if0.strt_glitch; assign gl_w[1] = if1.strt_glitch;
  assign pe_w[0] = if0.par_err;     assign pe_w[1] = if1.par_err;
  assign se_w[0] = if0.stp_err;     assign se_w[1] = if1.stp_err;
  assign busy_w[0] = if0.busy;      assign busy_w[1] = if1.busy;
  assign pd_w[0] = int'(if0.p_data);      assign pd_w[1] = int'(if1.p_data);
  assign gc_w[0] = int'(if0.glitch_cnt);  assign gc_w[1] = int'(if1.glitch_cnt);
  assign pc_w[0] = int'(if0.par_err_cnt); assign pc_w[1] = int'(if1.par_err_cnt);
  assign sc_w[0] = int'(if0.stp_err_cnt); assign sc_w[1] = int'(if1.stp_err_cnt);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_dv[2], n_gl[2], n_pe[2], n_se[2], n_excl[2], ev_cyc[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dv_w[i]) n_dv[i]++;
      if (gl_w[i]) n_gl[i]++;
      if (pe_w[i]) n_pe[i]++;
      if (se_w[i]) n_se[i]++;
      if ((dv_w[i] && (gl_w[i] || pe_w[i] || se_w[i])) || (gl_w[i] && (pe_w[i] || se_w[i])))
        n_excl[i]++;
      if (dv_w[i] || gl_w[i] || pe_w[i] || se_w[i]) ev_cyc[i] = cyc;
    end
  end

  int n_chk = 0;
  int n_bad = 0;
  int m_gc[2], m_pc[2], m_sc[2], m_pd[2];
  int cmax[2] = '{255, 3};
  int sbits[2] = '{1, 2};
  int edge_c[16];
  int fno = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      n_dv[i] = 0; n_gl[i] = 0; n_pe[i] = 0; n_se[i] = 0; n_excl[i] = 0; ev_cyc[i] = -1;
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s.u%0d.busy", tag, i), int'(busy_w[i]), 0);
      check_eq($sformatf("%s.u%0d.pdata", tag, i), pd_w[i], m_pd[i]);
      check_eq($sformatf("%s.u%0d.gcnt", tag, i), gc_w[i], m_gc[i]);
      check_eq($sformatf("%s.u%0d.pcnt", tag, i), pc_w[i], m_pc[i]);
      check_eq($sformatf("%s.u%0d.scnt", tag, i), sc_w[i], m_sc[i]);
    end
  endtask

  task automatic start_frame(input bit p_en, input bit p_typ);
    fs = 1'b1; pe = p_en; pt = p_typ;
    tick();
    fs = 1'b0; pe = $urandom_range(0, 1); pt = $urandom_range(0, 1);
  endtask

  task automatic send_bit(input int k, input logic b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    sv = 1'b1; sbit = b; edge_c[k] = cyc + 1;
    tick();
    sv = 1'b0; sbit = $urandom_range(0, 1);
  endtask

  // Frame-level expectation: decode the bit list directly, per stop-bit count.
  task automatic run_frame(input logic start, input logic [7:0] d, input bit p_en, input bit p_typ,
                           input logic pbit, input logic s1, input logic s2);
    logic [15:0] b;
    int nb, idx, last, eg, ep, es, edv;
    b = '0; b[0] = start; b[8:1] = d;
    if (p_en) begin b[9] = pbit; b[10] = s1; b[11] = s2; nb = 12; end
    else begin b[9] = s1; b[10] = s2; nb = 11; end
    fno++;
    clear_mon();
    start_frame(p_en, p_typ);
    for (int k = 0; k < nb; k++) send_bit(k, b[k], 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      eg = 0; ep = 0; es = 0; edv = 0; last = 0;
      if (start) begin
        eg = 1;
      end else begin
        idx = 9;
        if (p_en) begin
          ep = (pbit != ((^d) ^ p_typ)) ? 1 : 0;
          idx = 10;
        end
        for (int s = 0; s < sbits[i]; s++) if (b[idx + s] == 1'b0) es = 1;
        last = idx + sbits[i] - 1;
        edv = (ep == 0 && es == 0) ? 1 : 0;
      end
      if (eg != 0) m_gc[i] = sat_inc(m_gc[i], cmax[i]);
      if (ep != 0) m_pc[i] = sat_inc(m_pc[i], cmax[i]);
      if (es != 0) m_sc[i] = sat_inc(m_sc[i], cmax[i]);
      if (edv != 0) m_pd[i] = int'(d);
      check_eq($sformatf("f%0d.u%0d.dv", fno, i), n_dv[i], edv);
      check_eq($sformatf("f%0d.u%0d.glitch", fno, i), n_gl[i], eg);
      check_eq($sformatf("f%0d.u%0d.par_err", fno, i), n_pe[i], ep);
      check_eq($sformatf("f%0d.u%0d.stp_err", fno, i), n_se[i], es);
      check_eq($sformatf("f%0d.u%0d.excl", fno, i), n_excl[i], 0);
      check_eq($sformatf("f%0d.u%0d.latency", fno, i), ev_cyc[i], edge_c[last]);
    end
    check_idle_outputs($sformatf("f%0d", fno));
  endtask

  task automatic glitch_with_clear();
    clear_mon();
    start_frame(1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      m_gc[i] = 0; m_pc[i] = 0; m_sc[i] = 0;
      check_eq($sformatf("clr.u%0d.glitch", i), n_gl[i], 1);
    end
    check_idle_outputs("clr");
  endtask

  task automatic abort_frame(input bit use_rst);
    logic [7:0] d;
    d = 8'($urandom);
    clear_mon();
    start_frame(1'b0, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) send_bit(k, d[k-1], 1'b0);
    if (use_rst) rst = 1'b1; else chk_en = 1'b0;
    tick();
    if (use_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_gc[i] = 0; m_pc[i] = 0; m_sc[i] = 0; m_pd[i] = 0;
        check_eq($sformatf("rst.u%0d.dv", i), int'(dv_w[i]), 0);
        check_eq($sformatf("rst.u%0d.pulses", i), int'(gl_w[i] | pe_w[i] | se_w[i]), 0);
      end
      check_idle_outputs("rst_now");
    end else begin
      for (int i = 0; i < 2; i++)
        check_eq($sformatf("abort.u%0d.busy", i), int'(busy_w[i]), 0);
    end
    rst = 1'b0; chk_en = 1'b1;
    for (int k = 4; k <= 10; k++) send_bit(k, (k <= 8) ? d[k-1] : 1'b1, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("abort%0d.u%0d.pulses", use_rst, i), n_dv[i] + n_gl[i] + n_pe[i] + n_se[i], 0);
    end
    check_idle_outputs($sformatf("abort%0d", use_rst));
  endtask

  initial begin
    logic [7:0] d;
    bit r_pe, r_pt;
    rst = 1'b1; chk_en = 1'b1; fs = 1'b0; sv = 1'b0; sbit = 1'b0; pe = 1'b0; pt = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin m_gc[i] = 0; m_pc[i] = 0; m_sc[i] = 0; m_pd[i] = 0; end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("reset.u%0d.dv", i), int'(dv_w[i]), 0);
      check_eq($sformatf("reset.u%0d.glitch", i), int'(gl_w[i]), 0);
      check_eq($sformatf("reset.u%0d.par_err", i), int'(pe_w[i]), 0);
      check_eq($sformatf("reset.u%0d.stp_err", i), int'(se_w[i]), 0);
    end
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_frame(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) run_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    glitch_with_clear();
    abort_frame(1'b0);
    abort_frame(1'b1);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      r_pe = 1'($urandom_range(0, 1));
      r_pt = 1'($urandom_range(0, 1));
      run_frame(($urandom_range(0, 7) == 0), d, r_pe, r_pt,
                ((^d) ^ r_pt) ^ ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_chk.md
Name: uart_rx_frame_chk

Overview:
Parametrised UART receive frame checker for the RX path. It generalises the single-bit start-glitch check to the whole frame: start, data, optional parity and 1 or 2 stop bits. It consumes mid-bit samples from the data sampler and delivers the assembled word with per-frame error pulses and saturating error counters. It sits between the RX edge detector/data sampler and the RX output register.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9), LSB first
STOP_BITS, 1, number of stop bits checked (1 or 2)
CNT_W, 8, width of each saturating error counter

Ports:
CLK  in  1  system clock
RST  in  1  reset; reset is synchronous and active-high
chk_en  in  1  checker enable; low forces IDLE and aborts any frame in progress
frame_start  in  1  one-cycle pulse from edge detector on RX falling edge
sample_valid  in  1  one-cycle strobe: sampled_bit holds the current bit's majority sample
sampled_bit  in  1  sampled RX bit value
par_en  in  1  parity enable, latched on accepted frame_start
par_typ  in  1  0 = even, 1 = odd, latched on accepted frame_start
cnt_clr  in  1  synchronous clear of all error counters
busy  out  1  high from accepted frame_start until frame end or abort
p_data  out  DATA_WIDTH  received word, updated only with data_valid
data_valid  out  1  one-cycle pulse, frame error-free
strt_glitch  out  1  one-cycle pulse, start sample was 1
par_err  out  1  one-cycle pulse at frame end, parity mismatch
stp_err  out  1  one-cycle pulse at frame end, any stop sample was 0
glitch_cnt  out  CNT_W  saturating count of strt_glitch pulses
par_err_cnt  out  CNT_W  saturating count of par_err pulses
stp_err_cnt  out  CNT_W  saturating count of stp_err pulses

Behaviour:
- Reset: state IDLE; all outputs 0, including p_data and all counters; latched par_en/par_typ 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE. All transitions occur on the CLK edge at which sample_valid=1, except IDLE->START and DONE->IDLE.
- IDLE: frame_start & chk_en -> START. Latch par_en and par_typ; clear shift register, bit counter and running parity.
- START: on sample_valid, sampled_bit=1 -> strt_glitch pulse next cycle, return to IDLE. sampled_bit=0 -> DATA.
- DATA: on each sample_valid, shift sampled_bit in at the MSB and shift right (LSB first), and XOR it into the running parity. After DATA_WIDTH samples: -> PARITY if latched par_en, else -> STOP.
- PARITY: on sample_valid, par_err_flag = sampled_bit XOR running_parity XOR par_typ (even: expected bit = XOR of data bits). Then -> STOP.
- STOP: count STOP_BITS samples; any 0 sets stp_err_flag. After the last stop sample -> DONE.
- DONE (exactly one cycle): if neither flag is set, load p_data and pulse data_valid. Otherwise pulse the set flags; p_data keeps its previous value. Then -> IDLE.
- Output latency: every pulse is registered and appears in the cycle after the deciding edge. Pulses are mutually exclusive except par_err and stp_err, which may assert together.
- frame_start while busy is ignored; no re-sync mid-frame.
- chk_en low in any state: -> IDLE next cycle with no pulses emitted. Partial frame is discarded and counters are untouched.
- sample_valid in IDLE or DONE is ignored.
- Counters: each increments by 1 on its own pulse and saturates at 2^CNT_W-1 (no wrap). cnt_clr has priority over an increment in the same cycle, and that result is 0.
- RST mid-frame: the next cycle is in IDLE with all outputs 0. The reset is synchronous only, with no asynchronous path.

Decomposition:
- Package uart_rx_pkg holds the state encoding typedef (frame_state_t), PAR_EVEN/PAR_ODD constants and the legal ranges for DATA_WIDTH and STOP_BITS.
- One sub-module is natural: sat_counter (parameter W; ports inc, clr, count). It is instantiated three times.

Test Plan:
- DATA_WIDTH=8, par_en=0, frame 0 + 0xA5 LSB-first + 1 -> data_valid=1 and p_data=0xA5 one cycle after the stop sample; no error pulses.
- par_en=1, par_typ=0, data 0x07, parity bit 1 -> data_valid with 0x07. Repeat with parity bit 0 -> par_err=1, par_err_cnt=1, p_data unchanged.
- Start sample 1 after frame_start -> strt_glitch=1 for one cycle, glitch_cnt=1, busy drops; the following valid frame 0x3C is received correctly.
- STOP_BITS=2, second stop sample 0, parity also wrong -> par_err and stp_err both pulse in the same cycle; both counters increment.
- CNT_W=2, five glitches -> glitch_cnt stays at 3. cnt_clr in the same cycle as a glitch -> 0.
- Drop chk_en mid-DATA, and separately assert RST mid-DATA -> IDLE next cycle, no pulses. With RST, all outputs and counters read 0.
